// File: rtl/axi4_sram_slave.sv
// Single-beat AXI4 slave in front of a 64-bit synchronous SRAM.
// Bursts, oversize and out-of-window accesses are error-terminated without a memory access.
module axi4_sram_slave #(
   parameter int          MEM_AW    = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_axi_awvalid,
   output logic              io_axi_awready,
   input  logic              io_axi_awid,
   input  logic [31:0]       io_axi_awaddr,
   input  logic [2:0]        io_axi_awsize,
   input  logic [7:0]        io_axi_awlen,
   input  logic              io_axi_wvalid,
   output logic              io_axi_wready,
   input  logic [63:0]       io_axi_wdata,
   input  logic [7:0]        io_axi_wstrb,
   input  logic              io_axi_wlast,
   output logic              io_axi_bvalid,
   input  logic              io_axi_bready,
   output logic              io_axi_bid,
   output logic [1:0]        io_axi_bresp,
   input  logic              io_axi_arvalid,
   output logic              io_axi_arready,
   input  logic              io_axi_arid,
   input  logic [31:0]       io_axi_araddr,
   input  logic [2:0]        io_axi_arsize,
   input  logic [7:0]        io_axi_arlen,
   output logic              io_axi_rvalid,
   input  logic              io_axi_rready,
   output logic              io_axi_rid,
   output logic [63:0]       io_axi_rdata,
   output logic [1:0]        io_axi_rresp,
   output logic              io_axi_rlast,
   output logic              io_mem_en,
   output logic              io_mem_wen,
   output logic [MEM_AW-1:0] io_mem_addr,
   output logic [63:0]       io_mem_wdata,
   output logic [7:0]        io_mem_wmask,
   input  logic [63:0]       io_mem_rdata
);
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;
   localparam logic       PRIO_RD = 1'b0;
   localparam logic       PRIO_WR = 1'b1;

   typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_MEM, RD_CAP, RD_RESP} state_t;

   state_t     state, state_nxt;
   logic       prio;
   logic       aw_hs, ar_hs, w_hs;
   logic [1:0] aw_resp, ar_resp, wr_resp;
   logic       unused;

   function automatic logic [1:0] classify(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [2:0] size);
      if (addr[31:MEM_AW+3] != BASE_ADDR[31:MEM_AW+3]) return DECERR;
      if (len != 8'd0 || size > 3'd3) return SLVERR;
      return OKAY;
   endfunction

   assign aw_resp      = classify(io_axi_awaddr, io_axi_awlen, io_axi_awsize);
   assign ar_resp      = classify(io_axi_araddr, io_axi_arlen, io_axi_arsize);
   assign io_axi_rlast = io_axi_rvalid;
   // Sub-word address bits and wlast carry no information for a 64-bit single-beat port.
   assign unused       = ^{io_axi_wlast, io_axi_awaddr[2:0], io_axi_araddr[2:0]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      io_axi_awready = 1'b0;
      io_axi_arready = 1'b0;
      io_axi_wready  = 1'b0;
      aw_hs          = 1'b0;
      ar_hs          = 1'b0;
      w_hs           = 1'b0;
      case (state)
         IDLE: begin
            // With both channels valid exactly one ready is raised, chosen by prio.
            io_axi_awready = !io_axi_arvalid || prio == PRIO_WR;
            io_axi_arready = !io_axi_awvalid || prio == PRIO_RD;
            aw_hs          = io_axi_awvalid && io_axi_awready;
            ar_hs          = io_axi_arvalid && io_axi_arready;
            if (aw_hs)      state_nxt = WR_DATA;
            else if (ar_hs) state_nxt = (ar_resp == OKAY) ? RD_MEM : RD_RESP;
         end
         WR_DATA: begin
            io_axi_wready = 1'b1;
            w_hs          = io_axi_wvalid;
            if (w_hs) state_nxt = WR_RESP;
         end
         WR_RESP: if (io_axi_bready) state_nxt = IDLE;
         RD_MEM:  state_nxt = RD_CAP;
         RD_CAP:  state_nxt = RD_RESP;
         RD_RESP: if (io_axi_rready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prio          <= PRIO_RD;
         wr_resp       <= OKAY;
         io_axi_bvalid <= 1'b0;
         io_axi_bid    <= 1'b0;
         io_axi_bresp  <= OKAY;
         io_axi_rvalid <= 1'b0;
         io_axi_rid    <= 1'b0;
         io_axi_rdata  <= '0;
         io_axi_rresp  <= OKAY;
         io_mem_en     <= 1'b0;
         io_mem_wen    <= 1'b0;
         io_mem_addr   <= '0;
         io_mem_wdata  <= '0;
         io_mem_wmask  <= '0;
      end else begin
         io_mem_en  <= 1'b0;
         io_mem_wen <= 1'b0;
         if (aw_hs) begin
            prio        <= PRIO_RD;
            io_axi_bid  <= io_axi_awid;
            wr_resp     <= aw_resp;
            io_mem_addr <= io_axi_awaddr[MEM_AW+2:3];
         end
         if (ar_hs) begin
            prio         <= PRIO_WR;
            io_axi_rid   <= io_axi_arid;
            io_axi_rresp <= ar_resp;
            io_mem_addr  <= io_axi_araddr[MEM_AW+2:3];
            if (ar_resp == OKAY) begin
               io_mem_en <= 1'b1;
            end else begin
               io_axi_rvalid <= 1'b1;
               io_axi_rdata  <= '0;
            end
         end
         if (w_hs) begin
            io_axi_bvalid <= 1'b1;
            io_axi_bresp  <= wr_resp;
            if (wr_resp == OKAY) begin
               io_mem_en    <= 1'b1;
               io_mem_wen   <= 1'b1;
               io_mem_wdata <= io_axi_wdata;
               io_mem_wmask <= io_axi_wstrb;
            end
         end
         // SRAM data is valid the cycle after the enable, i.e. while in RD_CAP.
         if (state == RD_CAP) begin
            io_axi_rdata  <= io_mem_rdata;
            io_axi_rvalid <= 1'b1;
         end
         if (io_axi_bvalid && io_axi_bready) io_axi_bvalid <= 1'b0;
         if (io_axi_rvalid && io_axi_rready) io_axi_rvalid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Bench for axi4_sram_slave: directed scenarios plus random single-beat traffic,
// checked by a queue-based scoreboard against a byte-level memory model.
module tb_axi4_sram_slave;
   localparam int          MEM_AW = 4;
   localparam logic [31:0] BASE   = 32'h0000_1000;
   localparam int          WIN    = 1 << (MEM_AW + 3);

   logic clock = 1'b0, reset = 1'b1;
   logic awvalid = 0, awready, awid = 0; logic [31:0] awaddr = 0; logic [2:0] awsize = 0; logic [7:0] awlen = 0;
   logic wvalid = 0, wready, wlast = 0; logic [63:0] wdata = 0; logic [7:0] wstrb = 0;
   logic bvalid, bready = 1, bid; logic [1:0] bresp;
   logic arvalid = 0, arready, arid = 0; logic [31:0] araddr = 0; logic [2:0] arsize = 0; logic [7:0] arlen = 0;
   logic rvalid, rready = 1, rid, rlast; logic [63:0] rdata; logic [1:0] rresp;
   logic mem_en, mem_wen; logic [MEM_AW-1:0] mem_addr; logic [63:0] mem_wdata, mem_rdata = 0; logic [7:0] mem_wmask;

   always #5 clock = ~clock;

   axi4_sram_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
      .clock(clock), .reset(reset),
      .io_axi_awvalid(awvalid), .io_axi_awready(awready), .io_axi_awid(awid), .io_axi_awaddr(awaddr),
      .io_axi_awsize(awsize), .io_axi_awlen(awlen),
      .io_axi_wvalid(wvalid), .io_axi_wready(wready), .io_axi_wdata(wdata), .io_axi_wstrb(wstrb), .io_axi_wlast(wlast),
      .io_axi_bvalid(bvalid), .io_axi_bready(bready), .io_axi_bid(bid), .io_axi_bresp(bresp),
      .io_axi_arvalid(arvalid), .io_axi_arready(arready), .io_axi_arid(arid), .io_axi_araddr(araddr),
      .io_axi_arsize(arsize), .io_axi_arlen(arlen),
      .io_axi_rvalid(rvalid), .io_axi_rready(rready), .io_axi_rid(rid), .io_axi_rdata(rdata),
      .io_axi_rresp(rresp), .io_axi_rlast(rlast),
      .io_mem_en(mem_en), .io_mem_wen(mem_wen), .io_mem_addr(mem_addr), .io_mem_wdata(mem_wdata),
      .io_mem_wmask(mem_wmask), .io_mem_rdata(mem_rdata)
   );

   // Synchronous SRAM attached to the DUT memory port.
   logic [63:0] sram [2**MEM_AW];
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_wen) begin
            for (int b = 0; b < 8; b++)
               if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   int tests = 0, fails = 0, cyc = 0, ar_cyc = 0, w_cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: transaction-level memory image and arbitration preference.
   typedef struct { logic id; logic [1:0] resp; logic [63:0] data; int lat; } rsp_t;
   typedef struct { logic wen; logic [MEM_AW-1:0] addr; logic [63:0] data; logic [7:0] mask; } mop_t;
   rsp_t bq[$], rq[$];
   mop_t mq[$];
   logic [63:0] ref_mem [2**MEM_AW];
   logic m_prio_wr = 1'b0;
   logic rnd_ready = 1'b0;

   function automatic logic [1:0] ref_resp(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size);
      longint ua;
      ua = {32'd0, a};
      if (ua < longint'({32'd0, BASE}) || ua >= longint'({32'd0, BASE}) + WIN) return 2'd3;
      if (len != 0 || size > 3) return 2'd2;
      return 2'd0;
   endfunction

   task automatic model_read(input logic [31:0] a, input logic id, input logic [7:0] len, input logic [2:0] size);
      rsp_t r; mop_t m; int idx;
      r.id = id; r.resp = ref_resp(a, len, size); r.data = 64'd0; r.lat = 1;
      if (r.resp == 2'd0) begin
         idx = int'((a - BASE) >> 3);
         r.data = ref_mem[idx]; r.lat = 3;
         m.wen = 1'b0; m.addr = idx[MEM_AW-1:0]; m.data = 64'd0; m.mask = 8'd0;
         mq.push_back(m);
      end
      rq.push_back(r);
      m_prio_wr = 1'b1;
   endtask

   task automatic model_write(input logic [31:0] a, input logic id, input logic [7:0] len, input logic [2:0] size,
                              input logic [63:0] data, input logic [7:0] strb);
      rsp_t r; mop_t m; int idx;
      r.id = id; r.resp = ref_resp(a, len, size); r.data = 64'd0; r.lat = 1;
      if (r.resp == 2'd0) begin
         idx = int'((a - BASE) >> 3);
         for (int b = 0; b < 8; b++) if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
         m.wen = 1'b1; m.addr = idx[MEM_AW-1:0]; m.data = data; m.mask = strb;
         mq.push_back(m);
      end
      bq.push_back(r);
      m_prio_wr = 1'b0;
   endtask

   // Monitor: compares every response/memory access against the head of its queue.
   logic rv_prev = 0, bv_prev = 0;
   always @(negedge clock) begin
      if (reset) begin
         rv_prev <= 1'b0; bv_prev <= 1'b0;
      end else begin
         rv_prev <= rvalid; bv_prev <= bvalid;
         if (rvalid && !rv_prev && rq.size() > 0) chk("r_latency", 64'(cyc - ar_cyc), 64'(rq[0].lat));
         if (bvalid && !bv_prev && bq.size() > 0) chk("b_latency", 64'(cyc - w_cyc), 64'(bq[0].lat));
         if (rvalid && rready) begin
            if (rq.size() == 0) chk("r_unexpected", 1, 0);
            else begin
               chk("rid", rid, rq[0].id); chk("rresp", rresp, rq[0].resp);
               chk("rdata", rdata, rq[0].data); chk("rlast", rlast, 1);
               rq.delete(0);
            end
         end
         if (bvalid && bready) begin
            if (bq.size() == 0) chk("b_unexpected", 1, 0);
            else begin
               chk("bid", bid, bq[0].id); chk("bresp", bresp, bq[0].resp);
               bq.delete(0);
            end
         end
         if (mem_en) begin
            if (mq.size() == 0) chk("mem_unexpected", 1, 0);
            else begin
               chk("mem_wen", mem_wen, mq[0].wen); chk("mem_addr", mem_addr, mq[0].addr);
               chk("mem_cycle", 64'(cyc - (mq[0].wen ? w_cyc : ar_cyc)), 1);
               if (mq[0].wen) begin
                  chk("mem_wdata", mem_wdata, mq[0].data); chk("mem_wmask", mem_wmask, mq[0].mask);
               end
               mq.delete(0);
            end
         end
      end
   end

   task automatic wait_ar(input logic [31:0] a, input logic id, input logic [7:0] len, input logic [2:0] size,
                          output int n);
      for (n = 0; n < 60; n++) begin
         @(negedge clock);
         if (arready) break;
      end
      if (n == 60) chk("ar_timeout", 0, 1);
      else begin model_read(a, id, len, size); ar_cyc = cyc; end
      @(posedge clock); #1; arvalid = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input logic id, input logic [7:0] len, input logic [2:0] size);
      int n;
      @(posedge clock); #1;
      araddr = a; arid = id; arlen = len; arsize = size; arvalid = 1'b1;
      wait_ar(a, id, len, size, n);
   endtask

   task automatic send_w(input logic [63:0] data, input logic [7:0] strb);
      int n;
      @(posedge clock); #1;
      wdata = data; wstrb = strb; wlast = 1'b1; wvalid = 1'b1;
      for (n = 0; n < 60; n++) begin
         @(negedge clock);
         if (wready) break;
      end
      if (n == 60) chk("w_timeout", 0, 1);
      else w_cyc = cyc;
      @(posedge clock); #1; wvalid = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic id, input logic [7:0] len, input logic [2:0] size,
                           input logic [63:0] data, input logic [7:0] strb);
      int n;
      @(posedge clock); #1;
      awaddr = a; awid = id; awlen = len; awsize = size; awvalid = 1'b1;
      for (n = 0; n < 60; n++) begin
         @(negedge clock);
         if (awready) break;
      end
      if (n == 60) chk("aw_timeout", 0, 1);
      else model_write(a, id, len, size, data, strb);
      @(posedge clock); #1; awvalid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clock);
      send_w(data, strb);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         @(posedge clock); #1;
         if (rnd_ready) begin
            bready = ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
         end
         if (bq.size() == 0 && rq.size() == 0 && mq.size() == 0) return;
      end
      chk("idle_timeout", 0, 1);
      bq.delete(); rq.delete(); mq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      logic [63:0] snap_d;
      logic [1:0]  snap_r;
      logic        snap_i;
      for (int i = 0; i < 2**MEM_AW; i++) begin sram[i] = 64'd0; ref_mem[i] = 64'd0; end

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst_bvalid", bvalid, 0); chk("rst_rvalid", rvalid, 0); chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_wen", mem_wen, 0); chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wmask", mem_wmask, 0); chk("rst_rdata", rdata, 0); chk("rst_resp", {bresp, rresp}, 0);
      chk("rst_ids", {bid, rid}, 0); chk("rst_readies", {awready, arready, wready}, 3'b110);
      @(posedge clock); #1; reset = 1'b0;

      // Simultaneous AW+AR from reset, then a second AR contending with the still-pending AW.
      @(posedge clock); #1;
      awaddr = BASE + 32'h30; awid = 1; awlen = 0; awsize = 3; awvalid = 1'b1;
      araddr = BASE + 32'h30; arid = 0; arlen = 0; arsize = 3; arvalid = 1'b1;
      @(negedge clock);
      chk("contest1_arready", arready, !m_prio_wr); chk("contest1_awready", awready, m_prio_wr);
      if (arready) begin model_read(BASE + 32'h30, 0, 0, 3); ar_cyc = cyc; end
      @(posedge clock); #1; arid = 1;
      for (n = 0; n < 60; n++) begin
         @(negedge clock);
         if (awready || arready) break;
      end
      chk("contest2_awready", awready, m_prio_wr); chk("contest2_arready", arready, !m_prio_wr);
      if (awready) model_write(BASE + 32'h30, 1, 0, 3, 64'hA5A5_0000_1111_5A5A, 8'hFF);
      @(posedge clock); #1; awvalid = 1'b0;
      send_w(64'hA5A5_0000_1111_5A5A, 8'hFF);
      wait_ar(BASE + 32'h30, 1, 0, 3, n);
      wait_idle();

      // Basic write then read-back
      do_write(BASE + 32'h10, 1, 0, 3, 64'hDEADBEEF_01234567, 8'hFF); wait_idle();
      do_read(BASE + 32'h10, 1, 0, 3); wait_idle();

      // Error terminations
      do_read(BASE + WIN, 1, 0, 3); wait_idle();
      do_write(BASE + 32'h20, 0, 3, 3, 64'h1234, 8'hFF); wait_idle();
      do_read(BASE + 32'h28, 0, 0, 4); wait_idle();
      do_write(BASE - 8, 1, 0, 3, 64'h99, 8'hFF); wait_idle();

      // B backpressure with a pending AR
      bready = 1'b0;
      do_write(BASE + 32'h18, 1, 0, 3, 64'h0102_0304_0506_0708, 8'h0F);
      for (n = 0; n < 20 && !bvalid; n++) @(negedge clock);
      snap_i = bid; snap_r = bresp;
      araddr = BASE + 32'h18; arid = 0; arlen = 0; arsize = 3; arvalid = 1'b1;
      repeat (5) begin
         @(negedge clock);
         chk("bp_bvalid", bvalid, 1); chk("bp_bid", bid, snap_i); chk("bp_bresp", bresp, snap_r);
         chk("bp_arready", arready, 0);
      end
      @(posedge clock); #1; bready = 1'b1;
      do_read(BASE + 32'h18, 0, 0, 3);
      // R backpressure with a pending AW
      rready = 1'b0;
      for (n = 0; n < 20 && !rvalid; n++) @(negedge clock);
      snap_d = rdata; snap_i = rid; snap_r = rresp;
      awaddr = BASE + 32'h40; awid = 1; awlen = 0; awsize = 2; awvalid = 1'b1;
      repeat (5) begin
         @(negedge clock);
         chk("bp_rvalid", rvalid, 1); chk("bp_rdata", rdata, snap_d); chk("bp_rid", rid, snap_i);
         chk("bp_rresp", rresp, snap_r); chk("bp_awready", awready, 0);
      end
      @(posedge clock); #1; rready = 1'b1;
      do_write(BASE + 32'h40, 1, 0, 2, 64'hCAFE_F00D_0BAD_BEEF, 8'hF0); wait_idle();

      // Reset while the read is in its memory cycle: no response may appear
      @(posedge clock); #1;
      araddr = BASE + 32'h8; arid = 0; arlen = 0; arsize = 3; arvalid = 1'b1;
      for (n = 0; n < 20; n++) begin @(negedge clock); if (arready) break; end
      @(posedge clock); #1;
      chk("rst_mid_mem_en", mem_en, 1);
      arvalid = 1'b0; reset = 1'b1; m_prio_wr = 1'b0;
      repeat (2) @(posedge clock);
      #1; reset = 1'b0;
      repeat (5) begin @(negedge clock); chk("rst_mid_rvalid", rvalid, 0); end
      @(posedge clock); #1;
      araddr = BASE + 32'h8; arid = 1; arlen = 0; arsize = 3; arvalid = 1'b1;
      wait_ar(BASE + 32'h8, 1, 0, 3, n);
      chk("rst_mid_arready_wait", n, 0);
      wait_idle();

      // Random traffic with random response backpressure
      rnd_ready = 1'b1;
      for (int t = 0; t < 60; t++) begin
         logic [31:0] a; logic [7:0] len; logic [2:0] size; int sel;
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = $urandom;
         else if (sel == 1) a = BASE + WIN + $urandom_range(0, 63);
         else               a = BASE + $urandom_range(0, WIN - 1);
         len  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
         size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            do_write(a, 1'($urandom_range(0, 1)), len, size, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
         else
            do_read(a, 1'($urandom_range(0, 1)), len, size);
         wait_idle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
